// File: rtl/debouncer_pkg.sv
// Shared types and constants for the button front-end: channel state encoding,
// button bit positions and default timing for a 25 MHz clock.
package debouncer_pkg;

  typedef enum logic [1:0] {
    SUELTO      = 2'd0,
    ESPERA_PRES = 2'd1,
    PRESIONADO  = 2'd2,
    ESPERA_SOLT = 2'd3
  } estado_t;

  localparam int BTN_ARRIBA = 0;
  localparam int BTN_ABAJO  = 1;
  localparam int BTN_IZQ    = 2;
  localparam int BTN_DER    = 3;
  localparam int BTN_ELIGE  = 4;

  localparam int N_BOTONES_DEF      = 5;
  localparam int CICLOS_ESTABLE_DEF = 250000;    // 10 ms
  localparam int CNT_W_DEF          = 18;
  localparam int RETARDO_REP_DEF    = 12500000;  // 0.5 s
  localparam int PERIODO_REP_DEF    = 2500000;   // 0.1 s

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debouncer_botones_if.sv
// Button bundle between the board pins and the game controller:
// raw inputs one way, debounced levels and press pulses the other.
interface debouncer_botones_if #(
  parameter int N_BOTONES = 5
);
  logic [N_BOTONES-1:0] boton_in;
  logic [N_BOTONES-1:0] boton_nivel;
  logic [N_BOTONES-1:0] boton_pulso;

  modport master (output boton_in, input boton_nivel, input boton_pulso);
  modport slave  (input boton_in, output boton_nivel, output boton_pulso);
endinterface

// File: rtl/debouncer_canal.sv
// One button channel: 2-FF synchronizer, counter debounce FSM, registered level and pulse.
// Optional auto-repeat while held is enabled by defining REPETICION_EN.
module debouncer_canal
  import debouncer_pkg::*;
#(
  parameter int CICLOS_ESTABLE = CICLOS_ESTABLE_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int RETARDO_REP    = RETARDO_REP_DEF,
  parameter int PERIODO_REP    = PERIODO_REP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton_in,
  output logic nivel,
  output logic pulso
);

  if (CNT_W < $clog2(CICLOS_ESTABLE + 1) || CICLOS_ESTABLE < 2 ||
      RETARDO_REP < 1 || PERIODO_REP < 1) begin : g_param_check
    $error("debouncer_canal: invalid timing parameters");
  end

  logic [1:0]       sync_reg;
  logic             boton_s;
  estado_t          estado_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_fin;
  logic             nivel_reg;
  logic             pulso_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], boton_in};
    end
  end

  assign boton_s = sync_reg[1];
  assign cnt_inc = cnt_reg + CNT_W'(1);
  // The sample that moves into a waiting state is the first stable one,
  // so acceptance comes on the CICLOS_ESTABLE-th consecutive stable sample.
  assign cnt_fin = (cnt_inc >= CNT_W'(CICLOS_ESTABLE - 1));

`ifdef REPETICION_EN
  localparam int REP_W = $clog2(max2(RETARDO_REP, PERIODO_REP) + 1);

  logic [REP_W-1:0] rep_cnt_reg;
  logic [REP_W-1:0] rep_inc;
  logic [REP_W-1:0] rep_obj;
  logic             rep_fase_reg;   // 0: waiting initial delay, 1: periodic repeats

  assign rep_inc = rep_cnt_reg + REP_W'(1);
  assign rep_obj = rep_fase_reg ? REP_W'(PERIODO_REP) : REP_W'(RETARDO_REP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg   <= SUELTO;
      cnt_reg      <= '0;
      nivel_reg    <= 1'b0;
      pulso_reg    <= 1'b0;
`ifdef REPETICION_EN
      rep_cnt_reg  <= '0;
      rep_fase_reg <= 1'b0;
`endif
    end else begin
      pulso_reg <= 1'b0;
      case (estado_reg)
        SUELTO: begin
          if (boton_s) begin
            estado_reg <= ESPERA_PRES;
            cnt_reg    <= '0;
          end
        end
        ESPERA_PRES: begin
          if (!boton_s) begin
            estado_reg <= SUELTO;
            cnt_reg    <= '0;
          end else if (cnt_fin) begin
            estado_reg <= PRESIONADO;
            cnt_reg    <= '0;
            nivel_reg  <= 1'b1;
            pulso_reg  <= 1'b1;
`ifdef REPETICION_EN
            rep_cnt_reg  <= '0;
            rep_fase_reg <= 1'b0;
`endif
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        PRESIONADO: begin
          if (!boton_s) begin
            estado_reg <= ESPERA_SOLT;
            cnt_reg    <= '0;
`ifdef REPETICION_EN
            rep_cnt_reg  <= '0;
            rep_fase_reg <= 1'b0;
          end else if (rep_inc >= rep_obj) begin
            pulso_reg    <= 1'b1;
            rep_cnt_reg  <= '0;
            rep_fase_reg <= 1'b1;
          end else begin
            rep_cnt_reg <= rep_inc;
`endif
          end
        end
        ESPERA_SOLT: begin
          if (boton_s) begin
            // Bounce back to held: no pulse, repeat timing starts over
            estado_reg <= PRESIONADO;
            cnt_reg    <= '0;
`ifdef REPETICION_EN
            rep_cnt_reg  <= '0;
            rep_fase_reg <= 1'b0;
`endif
          end else if (cnt_fin) begin
            estado_reg <= SUELTO;
            cnt_reg    <= '0;
            nivel_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        default: begin
          estado_reg <= SUELTO;
          cnt_reg    <= '0;
          nivel_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign nivel = nivel_reg;
  assign pulso = pulso_reg;

endmodule

// File: rtl/debouncer_botones.sv
// Five-button debounce front-end for the tic-tac-toe controller: one independent
// debouncer_canal per button. Auto-repeat is built when REPETICION_EN is defined.
module debouncer_botones
  import debouncer_pkg::*;
#(
  parameter int N_BOTONES      = N_BOTONES_DEF,
  parameter int CICLOS_ESTABLE = CICLOS_ESTABLE_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int RETARDO_REP    = RETARDO_REP_DEF,
  parameter int PERIODO_REP    = PERIODO_REP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  debouncer_botones_if.slave  bus
);

  logic [N_BOTONES-1:0] nivel_w;
  logic [N_BOTONES-1:0] pulso_w;

  for (genvar gi = 0; gi < N_BOTONES; gi++) begin : g_canal
    debouncer_canal #(
      .CICLOS_ESTABLE (CICLOS_ESTABLE),
      .CNT_W          (CNT_W),
      .RETARDO_REP    (RETARDO_REP),
      .PERIODO_REP    (PERIODO_REP)
    ) u_canal (
      .clk      (clk),
      .rst_n    (rst_n),
      .boton_in (bus.boton_in[gi]),
      .nivel    (nivel_w[gi]),
      .pulso    (pulso_w[gi])
    );
  end

  assign bus.boton_nivel = nivel_w;
  assign bus.boton_pulso = pulso_w;

endmodule
